// File: rtl/q_serializer.sv
// Serializes a charge value into Q_PER_PULSE-sized pulses followed by a watchdog gap.
// The remainder q_in mod Q_PER_PULSE is published on q_residue when the frame completes.
module q_serializer #(
  parameter int unsigned BUS_WIDTH   = 10,
  parameter int unsigned Q_PER_PULSE = 30,
  parameter int unsigned PULSE_HIGH  = 1,
  parameter int unsigned PULSE_LOW   = 1,
  parameter int unsigned GAP_CYCLES  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BUS_WIDTH-1:0] q_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 q_serialized,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] q_residue
);

  localparam int unsigned TMAX_HL = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
  localparam int unsigned TMAX    = (TMAX_HL > GAP_CYCLES) ? TMAX_HL : GAP_CYCLES;
  localparam int unsigned TW      = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DIVIDE  = 3'd1,
    PULSE_H = 3'd2,
    PULSE_L = 3'd3,
    GAP     = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t               state;
  logic [BUS_WIDTH-1:0] residue;
  logic [BUS_WIDTH-1:0] count;
  logic [TW-1:0]        tmr;

  // Ready is held low during reset even though the state already reads IDLE.
  assign in_ready = (state == IDLE) && start && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      residue      <= '0;
      count        <= '0;
      tmr          <= '0;
      q_serialized <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      q_residue    <= '0;
    end else if (!start) begin
      // Synchronous abort: residue register and q_residue are left untouched.
      state        <= IDLE;
      count        <= '0;
      tmr          <= '0;
      q_serialized <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            residue <= q_in;
            count   <= '0;
            tmr     <= '0;
            busy    <= 1'b1;
            state   <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (residue >= BUS_WIDTH'(Q_PER_PULSE)) begin
            residue <= residue - BUS_WIDTH'(Q_PER_PULSE);
            count   <= count + BUS_WIDTH'(1);
          end else if (count != '0) begin
            tmr          <= '0;
            q_serialized <= 1'b1;
            state        <= PULSE_H;
          end else begin
            tmr   <= '0;
            state <= GAP;
          end
        end
        PULSE_H: begin
          if (tmr == TW'(PULSE_HIGH - 1)) begin
            tmr          <= '0;
            q_serialized <= 1'b0;
            state        <= PULSE_L;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        PULSE_L: begin
          if (tmr == TW'(PULSE_LOW - 1)) begin
            tmr   <= '0;
            count <= count - BUS_WIDTH'(1);
            if (count == BUS_WIDTH'(1)) begin
              state <= GAP;
            end else begin
              q_serialized <= 1'b1;
              state        <= PULSE_H;
            end
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        GAP: begin
          if (tmr == TW'(GAP_CYCLES - 1)) begin
            tmr       <= '0;
            done      <= 1'b1;
            q_residue <= residue;
            state     <= DONE;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy         <= 1'b0;
          q_serialized <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_q_serializer.sv
// Randomized bench for q_serializer; each frame is compared cycle by cycle
// against a waveform computed from N = q/Q_PER_PULSE and the pulse/gap timing.
module tb_q_serializer;

  localparam int unsigned BW  = 10;
  localparam int unsigned QP  = 30;
  localparam int unsigned PH  = 1;
  localparam int unsigned PL  = 1;
  localparam int unsigned GAP = 6;

  logic          clk;
  logic          rst;
  logic          start;
  logic [BW-1:0] q_in;
  logic          in_valid;
  logic          in_ready;
  logic          q_serialized;
  logic          busy;
  logic          done;
  logic [BW-1:0] q_residue;

  int n_cmp;
  int n_bad;
  int model_res;

  q_serializer #(
    .BUS_WIDTH  (BW),
    .Q_PER_PULSE(QP),
    .PULSE_HIGH (PH),
    .PULSE_LOW  (PL),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .q_in        (q_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .q_serialized(q_serialized),
    .busy        (busy),
    .done        (done),
    .q_residue   (q_residue)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference waveform: after edge k of the frame (k=1 is the accepting edge).
  function automatic int exp_ser(input int k, input int n);
    int j;
    if (k <= n + 1) return 0;
    j = k - (n + 2);
    if (j < n * int'(PH + PL)) return ((j % int'(PH + PL)) < int'(PH)) ? 1 : 0;
    return 0;
  endfunction

  // Entered and left on a negedge. abort_k / reset_k = 0 means no disturbance.
  task automatic run_frame(input int q, input int abort_k, input int reset_k);
    int n, res, len, rises;
    logic prev;
    n     = q / int'(QP);
    res   = q % int'(QP);
    len   = (n + 1) + n * int'(PH + PL) + int'(GAP) + 1;
    rises = 0;
    prev  = 1'b0;
    check("ready_idle", int'(in_ready), 1);
    q_in     = BW'(q);
    in_valid = 1'b1;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      check("ser", int'(q_serialized), exp_ser(k, n));
      check("busy", int'(busy), 1);
      check("done", int'(done), (k == len) ? 1 : 0);
      check("ready_busy", int'(in_ready), 0);
      if (q_serialized && !prev) rises++;
      prev = q_serialized;
      if (k == abort_k) begin
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_ser", int'(q_serialized), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_ready", int'(in_ready), 0);
        check("abort_res", int'(q_residue), model_res);
        start = 1'b1;
        @(negedge clk);
        check("abort_noframe", int'(busy), 0);
        return;
      end
      if (k == reset_k) begin
        #1 rst = 1'b0;
        #1;
        model_res = 0;
        check("rst_ser", int'(q_serialized), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_res", int'(q_residue), 0);
        check("rst_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_held_busy", int'(busy), 0);
        rst = 1'b1;
        @(posedge clk);
        #1 check("rst_release_ready", int'(in_ready), 1);
        check("rst_release_busy", int'(busy), 0);
        @(negedge clk);
        return;
      end
      // Junk on the input bus mid-frame must never be latched.
      in_valid = (k < len - 1) ? 1'($urandom) : 1'b0;
      q_in     = BW'($urandom);
    end
    @(negedge clk);
    model_res = res;
    check("end_done", int'(done), 0);
    check("end_busy", int'(busy), 0);
    check("end_ser", int'(q_serialized), 0);
    check("residue", int'(q_residue), res);
    check("pulses", rises, n);
    check("loopback", rises * int'(QP) + int'(q_residue), q);
    check("ready_after", int'(in_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int q;
    n_cmp     = 0;
    n_bad     = 0;
    model_res = 0;
    rst       = 1'b0;
    start     = 1'b1;
    in_valid  = 1'b0;
    q_in      = '0;
    repeat (2) @(negedge clk);
    check("reset_ser", int'(q_serialized), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_res", int'(q_residue), 0);
    check("reset_ready", int'(in_ready), 0);
    rst = 1'b1;
    @(negedge clk);

    run_frame(90, 0, 0);
    run_frame(29, 0, 0);
    run_frame(1023, 0, 0);
    run_frame(150, 5 + 1 + int'(PH + PL) + 1 + 1 - 2, 0);
    run_frame(60, 0, 0);
    run_frame(90, 0, 13);
    run_frame(120, 0, 0);
    run_frame(0, 0, 0);
    run_frame(30, 0, 0);
    for (int i = 0; i < 12; i++) begin
      q = int'($urandom_range(0, (1 << BW) - 1));
      run_frame(q, 0, 0);
    end
    q = int'($urandom_range(60, (1 << BW) - 1));
    run_frame(q, int'($urandom_range(1, (q / int'(QP)) + 1)), 0);
    run_frame(int'($urandom_range(0, (1 << BW) - 1)), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/q_serializer.md
Q_SERIALIZER -- requirements
Module: q_serializer

Interface
REQ-001 Parameter BUS_WIDTH, default 10: width of the charge value and residue buses.
REQ-002 Parameter Q_PER_PULSE, default 30: charge represented by one output pulse; SHALL be >= 1 and < 2**BUS_WIDTH.
REQ-003 Parameter PULSE_HIGH, default 1: cycles q_serialized is high per pulse; SHALL be >= 1.
REQ-004 Parameter PULSE_LOW, default 1: cycles q_serialized is low after each pulse; SHALL be >= 1.
REQ-005 Parameter GAP_CYCLES, default 6: idle-low cycles after the last pulse, sized to trip the receiving pulse-counter watchdog; SHALL be >= 1.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  enable; low = synchronous abort to IDLE.
REQ-009 q_in  input  BUS_WIDTH  charge value to serialize.
REQ-010 in_valid  input  1  q_in is valid.
REQ-011 in_ready  output  1  block can accept q_in.
REQ-012 q_serialized  output  1  serialized pulse train.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion strobe.
REQ-015 q_residue  output  BUS_WIDTH  q_in mod Q_PER_PULSE of the last completed frame.

Function
REQ-016 FSM states SHALL be IDLE, DIVIDE, PULSE_H, PULSE_L, GAP and DONE; in_ready = (state==IDLE && start).
REQ-017 Acceptance SHALL occur on an edge where in_valid && in_ready; q_in is latched into a residue register, the pulse count is cleared, and the next state is DIVIDE.
REQ-018 DIVIDE SHALL, per cycle, subtract Q_PER_PULSE from the residue and increment the count while residue >= Q_PER_PULSE; otherwise it SHALL exit. DIVIDE therefore lasts N+1 cycles, where N = floor(q_in/Q_PER_PULSE).
REQ-019 On DIVIDE exit, the next state SHALL be PULSE_H if N > 0, else GAP (zero pulses emitted).
REQ-020 PULSE_H SHALL drive q_serialized high for PULSE_HIGH cycles, then go to PULSE_L.
REQ-021 PULSE_L SHALL drive q_serialized low for PULSE_LOW cycles, then decrement the count; it goes to PULSE_H if the count is still nonzero, else to GAP.
REQ-022 Exactly N rising edges of q_serialized SHALL occur per frame; q_serialized is low in every state except PULSE_H.
REQ-023 GAP SHALL hold q_serialized low for GAP_CYCLES cycles, then go to DONE.
REQ-024 DONE SHALL last one cycle: done = 1, q_residue = final residue, then IDLE; done is 0 in all other states.
REQ-025 Latency: done SHALL be high (N+1) + N*(PULSE_HIGH+PULSE_LOW) + GAP_CYCLES + 1 edges after the accepting edge.
REQ-026 The count and residue registers SHALL be BUS_WIDTH bits; no overflow is possible, since N <= (2**BUS_WIDTH-1)/Q_PER_PULSE.
REQ-027 start low on any edge SHALL force IDLE on that edge: q_serialized = 0, count cleared, no done strobe, q_residue unchanged.
REQ-028 in_valid SHALL be ignored while state != IDLE; a new q_in is never latched mid-frame.
REQ-029 q_in = 2**BUS_WIDTH-1 SHALL produce floor((2**BUS_WIDTH-1)/Q_PER_PULSE) pulses with no wrap.

Reset
REQ-030 rst low SHALL immediately, independent of clk, force state=IDLE, q_serialized=0, busy=0, done=0, q_residue=0, and clear the count and residue registers.
REQ-031 in_ready SHALL be 0 while rst is low; normal operation resumes on the first clk edge after rst goes high.
REQ-032 rst asserted mid-frame SHALL abort the frame with no done strobe and no further pulses.

Verification
REQ-033 Defaults, q_in=90 accepted -> 4 DIVIDE cycles, 3 single-cycle highs alternating with lows, 6 low gap cycles, done high 17 edges after acceptance, q_residue=0.
REQ-034 q_in=29 -> zero pulses, q_serialized always low, done after 1+6+1=8 edges, q_residue=29.
REQ-035 q_in=1023 -> 34 pulses, q_residue=3, no wrap.
REQ-036 start dropped during the 2nd pulse of q_in=150 -> IDLE next edge, q_serialized=0, no done; next q_in=60 -> exactly 2 pulses.
REQ-037 rst low mid-GAP -> all outputs at reset values without a clk edge; in_ready=1 on the first edge after release with start=1.
REQ-038 Loopback into the pulse-counter receiver (WTD_BUS_WIDTH=2, Q_PER_PULSE=30), q_in=120 -> receiver reports 120 with its ready asserted during GAP.
